// File: rtl/fetch_buffer_pkg.sv
// Shared front-end definitions: instruction encodings used by fetch and decode,
// plus the occupancy-update encoding used by the queue controllers.
package fetch_buffer_pkg;

  localparam int INSTR_W = 32;

  // addi x0, x0, 0: the canonical RISC-V NOP presented to decode when idle.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // {push, pop} packed so the count update reads as a single case.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'b00,
    OCC_DEC  = 2'b01,
    OCC_INC  = 2'b10,
    OCC_BOTH = 2'b11
  } occ_op_t;

  function automatic occ_op_t occ_op(input logic push, input logic pop);
    return occ_op_t'({push, pop});
  endfunction

endpackage

// File: rtl/fetch_buffer_fifo_ctrl.sv
// Circular-FIFO bookkeeping: pointers, occupancy count, accept/full/empty.
// Holds no data, so the same controller can sit in front of any storage array.
module fifo_ctrl
  import fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_req,
  input  logic             pop_req,
  output logic             push,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic             pop;
  logic [CNT_W-1:0] count_next;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a full queue can still accept.
  // Flush and reset suppress both so nothing is written into a dead queue.
  assign pop  = pop_req && !empty && !flush && rst_n;
  assign push = push_req && (!full || pop) && !flush && rst_n;

  always_comb begin
    // NOTE: default first so every path assigns count_next and no latch is inferred.
    count_next = count;
    case (occ_op(push, pop))
      OCC_INC:  count_next = count + CNT_W'(1);
      OCC_DEC:  count_next = count - CNT_W'(1);
      default:  count_next = count;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: holds {instr, pc} pairs and
// presents the oldest one to decode, NOP-masked when the queue is empty.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WIDTH_PC = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_we,
  input  logic [INSTR_W-1:0]     i_instr,
  input  logic [WIDTH_PC-1:0]    i_pc,
  input  logic                   i_re,
  output logic [INSTR_W-1:0]     o_instr,
  output logic [WIDTH_PC-1:0]    o_pc,
  output logic                   o_imask,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = INSTR_W + WIDTH_PC;

  logic               push;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               empty;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;

  fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (i_flush),
    .push_req (i_we),
    .pop_req  (i_re),
    .push     (push),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (o_count),
    .full     (o_full),
    .empty    (empty)
  );

  // NOTE: the array has no reset; stale slots are never visible because the
  // outputs are gated by the controller's empty flag.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i_instr, i_pc};
  end

  assign head    = mem[rd_ptr];
  assign o_imask = !empty;
  assign o_instr = empty ? NOP_INSTR : head[ENTRY_W-1 -: INSTR_W];
  assign o_pc    = empty ? '0 : head[WIDTH_PC-1:0];

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: stimulus records expected {instr, pc} in a
// scoreboard queue; a negedge monitor compares the head whenever decode pops.
module tb_fetch_buffer;

  localparam int DEPTH    = 8;
  localparam int WIDTH_PC = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   i_flush = 1'b0;
  logic                   i_we = 1'b0;
  logic [31:0]            i_instr = '0;
  logic [WIDTH_PC-1:0]    i_pc = '0;
  logic                   i_re = 1'b0;
  logic [31:0]            o_instr;
  logic [WIDTH_PC-1:0]    o_pc;
  logic                   o_imask;
  logic                   o_full;
  logic [$clog2(DEPTH):0] o_count;

  logic [63:0] exp_q [$];
  logic [63:0] exp_head;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          started = 1'b0;

  fetch_buffer #(
    .DEPTH    (DEPTH),
    .WIDTH_PC (WIDTH_PC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_flush),
    .i_we    (i_we),
    .i_instr (i_instr),
    .i_pc    (i_pc),
    .i_re    (i_re),
    .o_instr (o_instr),
    .o_pc    (o_pc),
    .o_imask (o_imask),
    .o_full  (o_full),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one cycle's inputs, pass the edge, then update the scoreboard with
  // the hand-determined outcome of that edge.
  task automatic cycle(input logic rst, input logic fl, input logic we,
                       input logic [31:0] instr, input logic [31:0] pc,
                       input logic re, input logic accept);
    rst_n = rst; i_flush = fl; i_we = we; i_instr = instr; i_pc = pc; i_re = re;
    @(posedge clk);
    #1;
    if (!rst || fl) exp_q.delete();
    else if (accept) exp_q.push_back({instr, pc});
    rst_n = 1'b1; i_flush = 1'b0; i_we = 1'b0; i_re = 1'b0;
  endtask

  task automatic push_n(input logic [31:0] base_instr, input logic [31:0] base_pc, input int n);
    for (int k = 0; k < n; k++)
      cycle(1'b1, 1'b0, 1'b1, base_instr + 32'(k), base_pc + 32'(4 * k), 1'b0, 1'b1);
  endtask

  task automatic pop_n(input int n);
    for (int k = 0; k < n; k++)
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_imask"}, 64'(o_imask), 64'd0);
    check({tag, "_instr"}, 64'(o_instr), 64'(NOP));
    check({tag, "_pc"},    64'(o_pc),    64'd0);
    check({tag, "_count"}, 64'(o_count), 64'd0);
    check({tag, "_full"},  64'(o_full),  64'd0);
  endtask

  // Monitor: status against scoreboard occupancy every cycle, head on every pop.
  always @(negedge clk) begin
    if (started) begin
      check("mon_imask", 64'(o_imask), 64'(exp_q.size() != 0));
      check("mon_count", 64'(o_count), 64'(exp_q.size()));
      check("mon_full",  64'(o_full),  64'(exp_q.size() == DEPTH));
      if (!o_imask) begin
        check("mon_empty_instr", 64'(o_instr), 64'(NOP));
        check("mon_empty_pc",    64'(o_pc),    64'd0);
      end else if (i_re) begin
        check("mon_pop_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_head = exp_q.pop_front();
          check("mon_head_instr", 64'(o_instr), 64'(exp_head[63:32]));
          check("mon_head_pc",    64'(o_pc),    64'(exp_head[31:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    // Reset then idle.
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check_idle("reset");
    started = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check_idle("idle");

    // Fill to DEPTH, ninth push dropped, then drain in order.
    push_n(32'h00A0_0093, 32'h100, DEPTH);
    check("fill_full",  64'(o_full),  64'd1);
    check("fill_count", 64'(o_count), 64'd8);
    check("fill_head",  64'(o_instr), 64'h00A0_0093);
    cycle(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h900, 1'b0, 1'b0);
    check("drop_count", 64'(o_count), 64'd8);
    check("drop_head",  64'(o_pc),    64'h100);
    pop_n(DEPTH);
    check_idle("drained");

    // Full with simultaneous push and pop for three cycles.
    push_n(32'h00B0_0093, 32'h200, DEPTH);
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 1'b0, 1'b1, 32'h00C0_0093 + 32'(k), 32'h300 + 32'(4 * k), 1'b1, 1'b1);
    check("both_full_count", 64'(o_count), 64'd8);
    check("both_full_full",  64'(o_full),  64'd1);
    check("both_full_head",  64'(o_instr), 64'h00B0_0096);
    check("both_full_pc",    64'(o_pc),    64'h20C);
    pop_n(DEPTH);
    check_idle("wrap_drained");

    // Empty with simultaneous push and read: only the push happens.
    cycle(1'b1, 1'b0, 1'b1, 32'h0050_0113, 32'h400, 1'b1, 1'b1);
    check("empty_both_count", 64'(o_count), 64'd1);
    check("empty_both_head",  64'(o_instr), 64'h0050_0113);
    check("empty_both_pc",    64'(o_pc),    64'h400);
    pop_n(1);

    // Flush beats push and pop in the same cycle.
    push_n(32'h00D0_0093, 32'h500, 5);
    check("pre_flush_count", 64'(o_count), 64'd5);
    cycle(1'b1, 1'b1, 1'b1, 32'hBAD0_0BAD, 32'h5F0, 1'b1, 1'b0);
    check_idle("flush");
    push_n(32'h00E0_0093, 32'h600, 1);
    check("post_flush_head",  64'(o_instr), 64'h00E0_0093);
    check("post_flush_pc",    64'(o_pc),    64'h600);
    check("post_flush_count", 64'(o_count), 64'd1);
    pop_n(1);

    // Reset mid-operation with a push pending.
    push_n(32'h00F0_0093, 32'h700, 4);
    check("pre_reset_count", 64'(o_count), 64'd4);
    cycle(1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h7F0, 1'b0, 1'b0);
    check_idle("mid_reset");
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    check_idle("after_reset");

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction queue between the fetch stage and the decode stage. It stores fetched instruction words with their PCs in a small circular FIFO. It presents the oldest entry to decode as a valid-qualified instruction, and decode drives its instruction-mask input from that valid. A single-cycle flush empties the queue on redirect (mispredict, jump).

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥2
- `WIDTH_PC`, 32, PC width
- `clk` input 1: clock, rising edge
- `rst_n` input 1: synchronous, active-low reset
- `i_flush` input 1: discard all entries (front-end redirect)
- `i_we` input 1: fetch presents a valid instruction this cycle
- `i_instr` input 32: fetched instruction word
- `i_pc` input WIDTH_PC: PC of `i_instr`
- `i_re` input 1: decode consumes the head entry this cycle
- `o_instr` output 32: head instruction; NOP (32'h00000013) when empty
- `o_pc` output WIDTH_PC: head PC; 0 when empty
- `o_imask` output 1: head entry valid (= !empty)
- `o_full` output 1: no free entry; fetch must hold
- `o_count` output $clog2(DEPTH)+1: number of occupied entries

## Operation
- Storage: DEPTH × (32 + WIDTH_PC) array.
- Pointers: write and read pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy: a separate counter `count`, range 0..DEPTH.
- Push accepted: `push = i_we && (!full || pop)`.
  - On acceptance, write `{i_instr, i_pc}` at the write pointer and advance the write pointer.
- Pop: `pop = i_re && !empty`.
  - On pop, advance the read pointer.
  - `i_re` while empty is ignored, with no pointer movement.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push while full without a pop is dropped silently. Fetch is required to observe `o_full`.
- Push and pop in the same cycle:
  - When full, both happen, count stays DEPTH, and the new word lands in the slot just freed.
  - When empty, only the push occurs (the pop is invalid), and the count becomes 1.
- Flush:
  - `i_flush` has priority over push and pop in the same cycle.
  - Both pointers and `count` go to 0, and the incoming `i_we` word is discarded.
  - Array contents are not cleared.
- Outputs are combinational from the array at the read pointer, gated by `!empty`.
  - When empty, `o_instr` is the NOP constant, `o_pc` is 0 and `o_imask` is 0.
- `o_full = (count == DEPTH)`; `o_count = count`.

## Timing
- Reset (`rst_n` low at a rising edge):
  - Pointers and count go to 0.
  - Outputs after that edge: `o_imask` 0, `o_full` 0, `o_count` 0, `o_instr` NOP, `o_pc` 0.
  - Reset mid-stream behaves exactly like flush and takes priority over flush.
- Latency: a word pushed at edge N is visible on `o_instr`/`o_imask` after edge N (one cycle). There is no same-cycle bypass from `i_instr` to `o_instr`.
- Pop semantics: decode samples `o_instr` in the cycle it asserts `i_re`, and the next entry appears after the edge.
- `o_full` and `o_count` are updated at the edge that changes occupancy.
- Fetch back-pressure: fetch uses `o_full` from the same cycle. No extra skid entry is provided.
- Flush at edge N: queue is empty after edge N. A push at edge N+1 is visible after N+1.

## Structure
- The NOP encoding constant (32'h00000013) belongs in the shared opcode/type include used by decode, not local to this block.
- One natural sub-module: `fifo_ctrl`.
  - Holds the pointers, count, and push/pop/full/empty logic.
  - Parameterised by DEPTH and reusable for later issue/ROB queues.
- The data array stays in `fetch_buffer`.
- No state machine beyond the pointer/counter state.

## Test plan
- Reset then idle:
  - `rst_n`=0 for 2 cycles, then 1 with no `i_we`.
  - Required: `o_imask`=0, `o_instr`=32'h00000013, `o_pc`=0, `o_count`=0, `o_full`=0.
- Fill and drain, DEPTH=8:
  - Push 8 words 32'h00A00093+k with PC 0x100+4k, no `i_re`. Required: `o_full`=1, `o_count`=8.
  - A 9th push is dropped.
  - Pop 8 with `i_re`=1. Required: words return in order with matching PCs, then `o_imask`=0.
- Full with simultaneous push and pop:
  - At count=8, assert `i_we`+`i_re` for 3 cycles.
  - Required: count stays 8, the 3 new words appear after the original 8 in order, and the write pointer wraps correctly past index 7.
- Empty with simultaneous push and `i_re`:
  - Count 0, push 32'h00500113 with `i_re`=1.
  - Required: count 1 next cycle, head = 32'h00500113, and no underflow.
- Flush priority:
  - Count 5, assert `i_flush`, `i_we`, and `i_re` in one cycle.
  - Required: count 0, `o_imask`=0 next cycle, the pushed word is absent, and the next push becomes head.
- Reset mid-operation:
  - Count 4, assert `rst_n`=0 together with `i_we`.
  - Required: all outputs at reset values after the edge, and the queue is empty.
